prog_sequencer: RTL

PROG_SEQUENCER -- requirements
Module: prog_sequencer

---
 rtl/prog_sequencer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/prog_sequencer.sv
// prog_sequencer: launches one of three core programs per host request,
// supervises the run with a watchdog and reports completion.
module prog_sequencer #(
    parameter int PC_W     = 10,
    parameter int P1_START = 0,
    parameter int P2_START = 256,
    parameter int P3_START = 512,
    parameter int TIMEOUT  = 4096
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req,
    input  logic            halt,
    output logic            pc_load,
    output logic [PC_W-1:0] pc_start,
    output logic            run,
    output logic [1:0]      prog_id,
    output logic            ack,
    output logic            timeout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t          r_state;
    state_t          w_state_nx;
    logic            r_req_d;
    logic            r_armed;
    logic [15:0]     r_cnt;
    logic [15:0]     w_cnt_nx;
    logic            r_pc_load;
    logic            w_pc_load_nx;
    logic            r_run;
    logic            w_run_nx;
    logic            r_ack;
    logic            w_ack_nx;
    logic            r_timeout;
    logic            w_timeout_nx;
    logic [1:0]      r_prog_id;
    logic [1:0]      w_prog_id_nx;
    logic [PC_W-1:0] r_pc_start;
    logic [PC_W-1:0] w_pc_start_nx;

    logic            w_req_rise;
    logic [1:0]      w_id_inc;
    logic [PC_W-1:0] w_start_sel;

    // The armed flag blocks a request whose level was already high when
    // reset released: req must be seen low after reset before a rise counts.
    assign w_req_rise = req & ~r_req_d & r_armed;
    assign w_id_inc   = (r_prog_id == 2'd3) ? 2'd1 : r_prog_id + 2'd1;

    // Start address of the program that the next request would launch.
    always_comb begin
        w_start_sel = PC_W'(P3_START);
        unique case (1'b1)
            (w_id_inc == 2'd1): w_start_sel = PC_W'(P1_START);
            (w_id_inc == 2'd2): w_start_sel = PC_W'(P2_START);
            default:            w_start_sel = PC_W'(P3_START);
        endcase
    end

    // Next state and next registered output values.
    always_comb begin
        w_state_nx    = r_state;
        w_cnt_nx      = r_cnt;
        w_pc_load_nx  = 1'b0;
        w_run_nx      = r_run;
        w_ack_nx      = r_ack;
        w_timeout_nx  = r_timeout;
        w_prog_id_nx  = r_prog_id;
        w_pc_start_nx = r_pc_start;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_req_rise) begin
                    w_state_nx    = S_LOAD;
                    w_pc_load_nx  = 1'b1;
                    w_prog_id_nx  = w_id_inc;
                    w_pc_start_nx = w_start_sel;
                    w_ack_nx      = 1'b0;
                    w_timeout_nx  = 1'b0;
                end
            end
            S_LOAD: begin
                w_state_nx = S_RUN;
                w_run_nx   = 1'b1;
                w_cnt_nx   = 16'd0;
            end
            S_RUN: begin
                if (halt) begin
                    w_state_nx   = S_DONE;
                    w_run_nx     = 1'b0;
                    w_ack_nx     = 1'b1;
                    w_timeout_nx = 1'b0;
                end else if (r_cnt == TO_LAST) begin
                    w_state_nx   = S_DONE;
                    w_run_nx     = 1'b0;
                    w_ack_nx     = 1'b1;
                    w_timeout_nx = 1'b1;
                end else begin
                    w_cnt_nx = r_cnt + 16'd1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_run_nx   = 1'b0;
            end
        endcase
    end

    // State, watchdog and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_req_d    <= 1'b0;
            r_armed    <= 1'b0;
            r_cnt      <= 16'd0;
            r_pc_load  <= 1'b0;
            r_run      <= 1'b0;
            r_ack      <= 1'b0;
            r_timeout  <= 1'b0;
            r_prog_id  <= 2'd0;
            r_pc_start <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_req_d    <= req;
            r_armed    <= r_armed | ~req;
            r_cnt      <= w_cnt_nx;
            r_pc_load  <= w_pc_load_nx;
            r_run      <= w_run_nx;
            r_ack      <= w_ack_nx;
            r_timeout  <= w_timeout_nx;
            r_prog_id  <= w_prog_id_nx;
            r_pc_start <= w_pc_start_nx;
        end
    end

    assign pc_load  = r_pc_load;
    assign pc_start = r_pc_start;
    assign run      = r_run;
    assign prog_id  = r_prog_id;
    assign ack      = r_ack;
    assign timeout  = r_timeout;

endmodule
